fifo_byte_unpacker: RTL and testbench
=====================================

Name: fifo_byte_unpacker

Overview:
- Read-side consumer for a same-clock FIFO.
- Drains fixed-width words from the FIFO's read port (rd_en / dout / valid / empty, data one cycle after rd_en).
- Presents them downstream as a byte stream with a valid/ready handshake, most significant byte first.
- A 2-word prefetch buffer hides the FIFO's one-cycle read latency, so byte throughput is sustained at one byte per clock.

Parameters:
- word_bytes, 4, bytes per FIFO word; FIFO data width is 8*word_bytes; legal range 1..16.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active high.
- fifo_dout  input  8*word_bytes  FIFO read data; meaningful when fifo_valid=1.
- fifo_valid  input  1  FIFO read acknowledge: rd_en was high the previous cycle and data is on fifo_dout.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rd_en  output  1  FIFO read enable.
- flush  input  1  synchronous discard of all buffered and in-flight data.
- byte_out  output  8  current byte.
- byte_valid  output  1  byte_out holds a valid byte.
- byte_ready  input  1  downstream accepts byte_out this cycle.
- words_held  output  2  words currently buffered (0..2).

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (rst=1 at a rising edge):
  - fifo_rd_en=0, byte_valid=0, byte_out=0, words_held=0.
  - Byte index=0; in-flight flag cleared.
  - Reset wins over flush and all other inputs.
  - Reset mid-operation drops buffered words; a FIFO word returning the cycle after reset is discarded.
- State:
  - 2-entry word buffer (head, tail) and occupancy occ (0..2).
  - Byte index idx (0..word_bytes-1) into the head word.
  - inflight = registered copy of fifo_rd_en.
- Output path:
  - byte_valid = (occ>0).
  - byte_out = head[8*(word_bytes-idx)-1 -: 8], i.e. idx=0 gives the MSB byte; 0 when occ=0.
  - Both are decoded from registers only; there is no combinational path from byte_ready to byte_valid/byte_out.
  - xfer = byte_valid & byte_ready.
  - On xfer with idx<word_bytes-1: idx++.
  - On xfer with idx=word_bytes-1: idx<=0, pop head (tail moves to head).
  - pop = xfer & (idx==word_bytes-1).
- Read issue:
  - fifo_rd_en = ~rst & ~flush & ~fifo_empty & ((occ + inflight - pop) < 2).
  - This is combinational from byte_ready through pop; the path is accepted and documented.
  - The buffer never overflows.
- Word capture:
  - When inflight=1, fifo_valid=1 and no discard pending, the word is written to the first free entry, computed after this cycle's pop.
  - Push and pop in the same cycle are legal; occ is unchanged.
  - inflight=1 with fifo_valid=0 (FIFO underflow because the empty flag lagged): nothing is written and inflight clears. This is not an error.
  - fifo_valid=1 while inflight=0 is ignored.
- Flush:
  - In the flush cycle fifo_rd_en=0.
  - Next state: occ=0, idx=0, byte_valid=0.
  - If inflight=1 during flush, the word returned on the following cycle is discarded.
  - A byte accepted in the flush cycle is still considered consumed.
- Latency:
  - First fifo_rd_en in the cycle after fifo_empty falls (buffer empty).
  - Word captured at the next edge; byte_valid=1 one cycle later.
  - Total: 2 clocks from rd_en to first byte_valid.
- Throughput: with byte_ready held high and the FIFO non-empty, byte_valid stays high every cycle, for any word_bytes including 1.
- Backpressure:
  - byte_ready=0 holds byte_out, byte_valid and idx stable.
  - Reads stop once occ+inflight=2.
- words_held = occ.

Test Plan:
- Reset/idle:
  - Stimulus: assert rst 2 cycles with fifo_empty=0.
  - Required: fifo_rd_en=0, byte_valid=0, byte_out=0, words_held=0 throughout and in the first post-reset cycle's registered outputs.
- Basic unpack (word_bytes=4):
  - Stimulus: FIFO holds 0x11223344, 0xAABBCCDD; byte_ready=1.
  - Required: byte_out sequence 11,22,33,44,AA,BB,CC,DD on 8 consecutive valid cycles; byte_valid first high 2 clocks after first fifo_rd_en.
- Backpressure:
  - Stimulus: FIFO holds 4 words; byte_ready=0 for 10 cycles, then 1.
  - Required: exactly 2 rd_en pulses during the stall, words_held=2, byte_out stable at first byte; after release, all 16 bytes in order with no gaps.
- word_bytes=1 streaming:
  - Stimulus: 32 bytes 0x00..0x1F; byte_ready=1.
  - Required: 32 consecutive valid cycles with no bubble; no fifo_valid lost.
- Flush with in-flight read:
  - Stimulus: assert flush in the cycle after a rd_en.
  - Required: returning word is dropped, byte_valid=0 for 2 cycles, next bytes come from the following FIFO word, idx restarts at MSB.
- Lagging empty/underflow:
  - Stimulus: one word in FIFO; fifo_empty deasserts 1 cycle late; a rd_en hits empty and fifo_valid stays 0.
  - Required: words_held never exceeds the real count; no spurious bytes; normal operation resumes.

Source files
------------

// File: rtl/fifo_byte_unpacker.sv
// Read-side consumer for a same-clock FIFO: prefetches up to two words and
// presents them as an MSB-first byte stream with a valid/ready handshake.
module fifo_byte_unpacker #(
  parameter int unsigned word_bytes = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [8*word_bytes-1:0] fifo_dout_i,
  input  logic                    fifo_valid_i,
  input  logic                    fifo_empty_i,
  output logic                    fifo_rd_en_o,
  input  logic                    flush_i,
  output logic [7:0]              byte_out_o,
  output logic                    byte_valid_o,
  input  logic                    byte_ready_i,
  output logic [1:0]              words_held_o
);

  localparam int unsigned data_w = 8 * word_bytes;
  localparam int unsigned idx_w  = (word_bytes > 1) ? $clog2(word_bytes) : 1;
  localparam logic [idx_w-1:0] last_idx = idx_w'(word_bytes - 1);

  logic [data_w-1:0] head_q, head_d;
  logic [data_w-1:0] tail_q, tail_d;
  logic [1:0]        occ_q, occ_d;
  logic [1:0]        occ_mid;
  logic [idx_w-1:0]  idx_q, idx_d;
  logic              inflight_q, inflight_d;
  logic              xfer;
  logic              pop;
  logic              push;
  logic [2:0]        pending;

  assign byte_valid_o = (occ_q != 2'd0);
  assign byte_out_o   = byte_valid_o ? head_q[{last_idx - idx_q, 3'b000} +: 8] : 8'h00;
  assign words_held_o = occ_q;

  assign xfer = byte_valid_o & byte_ready_i;
  assign pop  = xfer & (idx_q == last_idx);

  // A word returning during a flush is dropped here; one returning after a
  // flush or reset is dropped because inflight_q is already clear.
  assign push = inflight_q & fifo_valid_i & ~flush_i;

  // Combinational from byte_ready_i through pop: lets a read be issued in the
  // same cycle the head word drains, which is what sustains 1 byte/clock.
  assign pending      = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign fifo_rd_en_o = ~rst_i & ~flush_i & ~fifo_empty_i & (pending < 3'd2);
  assign inflight_d   = fifo_rd_en_o;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    idx_d   = idx_q;
    occ_mid = occ_q - {1'b0, pop};
    occ_d   = occ_mid;

    if (xfer) begin
      if (idx_q == last_idx) begin
        idx_d  = '0;
        head_d = tail_q;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end

    if (push) begin
      if (occ_mid == 2'd0) begin
        head_d = fifo_dout_i;
      end else begin
        tail_d = fifo_dout_i;
      end
      occ_d = occ_mid + 2'd1;
    end

    if (flush_i) begin
      occ_d = 2'd0;
      idx_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q     <= '0;
      tail_q     <= '0;
      occ_q      <= 2'd0;
      idx_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      occ_q      <= occ_d;
      idx_q      <= idx_d;
      inflight_q <= inflight_d;
    end
  end

endmodule

// File: tb/tb_fifo_byte_unpacker.sv
// Scoreboard bench for fifo_byte_unpacker: a 4-byte-word instance and a
// 1-byte-word instance, each fed by a behavioural FIFO model.
module tb_fifo_byte_unpacker;

  logic        clk;
  logic        rst;

  logic [31:0] a_dout;
  logic        a_valid, a_empty, a_rd, a_flush, a_bv, a_ready;
  logic [7:0]  a_byte;
  logic [1:0]  a_held;

  logic [7:0]  b_dout;
  logic        b_valid, b_empty, b_rd, b_flush, b_bv, b_ready;
  logic [7:0]  b_byte;
  logic [1:0]  b_held;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  a_exp[$];
  logic [7:0]  b_exp[$];
  logic [31:0] a_fifo[$];
  logic [7:0]  b_fifo[$];

  logic a_lag = 1'b0;
  logic a_spur = 1'b0;
  logic a_empty_prev = 1'b0;

  logic       a_rd_s, a_bv_s, b_rd_s, b_bv_s;
  logic [7:0] a_byte_s;
  logic [1:0] a_held_s;
  int a_rd_cnt = 0;
  int b_rd_cnt = 0;
  int b_valid_cnt = 0;

  fifo_byte_unpacker #(.word_bytes(4)) u_dut_a (
    .clk_i        (clk),
    .rst_i        (rst),
    .fifo_dout_i  (a_dout),
    .fifo_valid_i (a_valid),
    .fifo_empty_i (a_empty),
    .fifo_rd_en_o (a_rd),
    .flush_i      (a_flush),
    .byte_out_o   (a_byte),
    .byte_valid_o (a_bv),
    .byte_ready_i (a_ready),
    .words_held_o (a_held)
  );

  fifo_byte_unpacker #(.word_bytes(1)) u_dut_b (
    .clk_i        (clk),
    .rst_i        (rst),
    .fifo_dout_i  (b_dout),
    .fifo_valid_i (b_valid),
    .fifo_empty_i (b_empty),
    .fifo_rd_en_o (b_rd),
    .flush_i      (b_flush),
    .byte_out_o   (b_byte),
    .byte_valid_o (b_bv),
    .byte_ready_i (b_ready),
    .words_held_o (b_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitors: compare every accepted byte against the queue head.
  always @(negedge clk) begin
    if (a_bv === 1'b1 && a_ready === 1'b1) begin
      if (a_exp.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL a_extra_byte: got %0h, expected no byte", a_byte);
      end else begin
        chk("a_byte_out", 32'(a_byte), 32'(a_exp.pop_front()));
      end
    end
    if (b_bv === 1'b1 && b_ready === 1'b1) begin
      if (b_exp.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL b_extra_byte: got %0h, expected no byte", b_byte);
      end else begin
        chk("b_byte_out", 32'(b_byte), 32'(b_exp.pop_front()));
      end
    end
  end

  // One clock: sample DUT at negedge, then apply FIFO model response after posedge.
  task automatic tick();
    @(negedge clk);
    a_rd_s   = a_rd;
    a_bv_s   = a_bv;
    a_byte_s = a_byte;
    a_held_s = a_held;
    b_rd_s   = b_rd;
    b_bv_s   = b_bv;
    if (a_rd_s === 1'b1) a_rd_cnt++;
    if (b_rd_s === 1'b1) b_rd_cnt++;
    @(posedge clk);
    #1;
    if (a_rd_s === 1'b1 && a_fifo.size() > 0) begin
      a_dout  = a_fifo.pop_front();
      a_valid = 1'b1;
    end else if (a_spur) begin
      a_dout  = 32'hBADBAD00;
      a_valid = 1'b1;
    end else begin
      a_valid = 1'b0;
    end
    a_empty      = a_lag ? a_empty_prev : (a_fifo.size() == 0);
    a_empty_prev = (a_fifo.size() == 0);
    if (b_rd_s === 1'b1 && b_fifo.size() > 0) begin
      b_dout  = b_fifo.pop_front();
      b_valid = 1'b1;
      b_valid_cnt++;
    end else begin
      b_valid = 1'b0;
    end
    b_empty = (b_fifo.size() == 0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic a_load(input logic [31:0] w, input bit expect_it);
    a_fifo.push_back(w);
    if (expect_it) begin
      for (int i = 3; i >= 0; i--) a_exp.push_back(w[8*i +: 8]);
    end
  endtask

  initial begin
    int  t_rd, t_bv, run_len, gaps, cnt;
    bit  found, stable;
    logic [1:0] held_max;

    rst = 1'b1;
    a_flush = 1'b0; b_flush = 1'b0;
    a_ready = 1'b1; b_ready = 1'b1;
    a_valid = 1'b0; b_valid = 1'b0;
    a_dout = '0;    b_dout = '0;
    a_empty = 1'b0; b_empty = 1'b1;

    // Reset with a non-empty FIFO; these two words are the basic unpack data.
    a_load(32'h11223344, 1'b1);
    a_load(32'hAABBCCDD, 1'b1);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_rd_en",   32'(a_rd_s),   32'd0);
      chk("rst_valid",   32'(a_bv_s),   32'd0);
      chk("rst_byte",    32'(a_byte_s), 32'd0);
      chk("rst_held",    32'(a_held_s), 32'd0);
    end
    rst = 1'b0;
    tick();
    chk("post_rst_valid", 32'(a_bv_s),   32'd0);
    chk("post_rst_byte",  32'(a_byte_s), 32'd0);
    chk("post_rst_held",  32'(a_held_s), 32'd0);

    // Basic unpack: first byte 2 clocks after first rd_en, 8 back-to-back bytes.
    t_rd = (a_rd_s === 1'b1) ? 0 : -1;
    t_bv = -1;
    run_len = 0;
    for (int c = 1; c < 30; c++) begin
      tick();
      if (a_rd_s === 1'b1 && t_rd < 0) t_rd = c;
      if (a_bv_s === 1'b1) begin
        if (t_bv < 0) t_bv = c;
        run_len++;
      end else if (t_bv >= 0) begin
        break;
      end
    end
    chk("first_byte_latency", 32'(t_bv - t_rd), 32'd2);
    chk("basic_run_len",      32'(run_len),     32'd8);

    // fifo_valid without a pending read must be ignored.
    a_spur = 1'b1;
    tick();
    a_spur = 1'b0;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (a_bv_s !== 1'b0 || a_held_s !== 2'd0) cnt++;
    end
    chk("spurious_valid_ignored", 32'(cnt), 32'd0);

    // Backpressure: reads stop at two words, output holds the first byte.
    a_ready = 1'b0;
    a_rd_cnt = 0;
    a_load(32'hA0A1A2A3, 1'b1);
    a_load(32'hB0B1B2B3, 1'b1);
    a_load(32'hC0C1C2C3, 1'b1);
    a_load(32'hD0D1D2D3, 1'b1);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (a_bv_s === 1'b1 && a_byte_s !== 8'hA0) stable = 1'b0;
    end
    chk("bp_rd_pulses",  32'(a_rd_cnt), 32'd2);
    chk("bp_held",       32'(a_held_s), 32'd2);
    chk("bp_valid",      32'(a_bv_s),   32'd1);
    chk("bp_byte",       32'(a_byte_s), 32'hA0);
    chk("bp_stable",     32'(stable),   32'd1);
    a_ready = 1'b1;
    gaps = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (a_bv_s !== 1'b1) gaps++;
    end
    chk("bp_release_gaps", 32'(gaps), 32'd0);
    run(6);
    chk("bp_drained", 32'(a_exp.size()), 32'd0);

    // Reset mid-operation drops buffered words.
    a_ready = 1'b0;
    a_load(32'h01234567, 1'b0);
    a_load(32'h89ABCDEF, 1'b0);
    found = 1'b0;
    for (int c = 0; c < 12 && !found; c++) begin
      tick();
      found = (a_held_s == 2'd2);
    end
    chk("midrst_filled", 32'(found), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("midrst_held",  32'(a_held_s), 32'd0);
    chk("midrst_valid", 32'(a_bv_s),   32'd0);
    a_ready = 1'b1;

    // Flush the cycle after rd_en: returning word dropped, next word used.
    a_load(32'hDEADBEEF, 1'b0);
    a_load(32'h01020304, 1'b1);
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      tick();
      found = (a_rd_s === 1'b1);
    end
    chk("flush_rd_seen", 32'(found), 32'd1);
    a_flush = 1'b1;
    tick();
    a_flush = 1'b0;
    chk("flush_rd_low", 32'(a_rd_s), 32'd0);
    tick();
    chk("flush_gap1", 32'(a_bv_s), 32'd0);
    tick();
    chk("flush_gap2", 32'(a_bv_s), 32'd0);
    tick();
    chk("flush_resume_valid", 32'(a_bv_s),   32'd1);
    chk("flush_resume_byte",  32'(a_byte_s), 32'h01);
    run(6);

    // Flush mid-word: the byte taken in the flush cycle counts; idx restarts.
    a_ready = 1'b0;
    a_fifo.push_back(32'h55667788);
    a_exp.push_back(8'h55);
    a_exp.push_back(8'h66);
    a_exp.push_back(8'h77);
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      tick();
      found = (a_held_s == 2'd1);
    end
    chk("midflush_filled", 32'(found), 32'd1);
    a_ready = 1'b1;
    tick();
    tick();
    a_flush = 1'b1;
    tick();
    a_flush = 1'b0;
    tick();
    chk("midflush_valid", 32'(a_bv_s),   32'd0);
    chk("midflush_held",  32'(a_held_s), 32'd0);
    a_load(32'h99AABBCC, 1'b1);
    run(10);

    // Lagging empty flag: one read underflows, nothing spurious appears.
    a_lag = 1'b1;
    a_rd_cnt = 0;
    held_max = 2'd0;
    a_load(32'h0F1E2D3C, 1'b1);
    for (int i = 0; i < 12; i++) begin
      tick();
      if (a_held_s > held_max) held_max = a_held_s;
    end
    chk("lag_rd_pulses", 32'(a_rd_cnt), 32'd2);
    chk("lag_held_max",  32'(held_max), 32'd1);
    a_lag = 1'b0;
    a_load(32'h4B5A6978, 1'b1);
    run(10);

    // word_bytes=1 streaming: 32 bytes with no bubble.
    b_rd_cnt = 0;
    b_valid_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      b_fifo.push_back(8'(i));
      b_exp.push_back(8'(i));
    end
    run_len = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (b_bv_s === 1'b1) run_len++;
      else if (run_len > 0) break;
    end
    chk("b_run_len",     32'(run_len),     32'd32);
    chk("b_rd_pulses",   32'(b_rd_cnt),    32'd32);
    chk("b_valid_count", 32'(b_valid_cnt), 32'd32);

    run(5);
    chk("a_all_bytes_seen", 32'(a_exp.size()), 32'd0);
    chk("b_all_bytes_seen", 32'(b_exp.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
